// File: rtl/ffe_coeff_bank.sv
// rtl/ffe_coeff_bank.sv - FFE tap weight bank: init walk, adaptation capture, freeze/hold, host access, status.
module ffe_coeff_bank #(
  parameter int FFE_LEN    = 21,
  parameter int NB         = 8,
  parameter int NBF        = 7,
  parameter int CENTER_TAP = FFE_LEN / 2,
  parameter int NB_ADDR    = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_update_en,
  input  logic [FFE_LEN*NB-1:0] i_new_coeff,
  input  logic                  i_freeze,
  input  logic                  i_reinit,
  input  logic                  i_host_wr,
  input  logic                  i_host_rd,
  input  logic [NB_ADDR-1:0]    i_host_addr,
  input  logic [NB-1:0]         i_host_wdata,
  output logic [NB-1:0]         o_host_rdata,
  output logic                  o_host_rvalid,
  output logic                  o_host_err,
  output logic [FFE_LEN*NB-1:0] o_coeff_flat,
  output logic                  o_ready,
  output logic [31:0]           o_update_count,
  output logic [NB_ADDR-1:0]    o_sat_taps
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_HOLD} state_t;

  localparam logic [NB-1:0]      INIT_VAL = NB'((2 ** NBF) - 1);
  localparam logic [NB-1:0]      SAT_POS  = {1'b0, {(NB-1){1'b1}}};
  localparam logic [NB-1:0]      SAT_NEG  = {1'b1, {(NB-1){1'b0}}};
  localparam logic [NB_ADDR-1:0] LAST_PTR = NB_ADDR'(FFE_LEN - 1);

  state_t             r_state, w_state_nxt;
  logic [NB_ADDR-1:0] r_ptr, w_ptr_nxt;
  logic [NB-1:0]      r_taps [FFE_LEN];
  logic [NB-1:0]      w_taps_nxt [FFE_LEN];
  logic [NB-1:0]      r_rdata, w_rdata_nxt;
  logic               r_rvalid, w_rvalid_nxt;
  logic               r_err, w_err_nxt;
  logic               r_ready;
  logic [31:0]        r_count;
  logic [NB_ADDR-1:0] r_sat, w_sat_cnt;
  logic [NB-1:0]      w_rd_tap;
  logic               w_addr_ok;
  logic               w_wr_ok;

  assign w_addr_ok = (32'(i_host_addr) < 32'(FFE_LEN));
  assign w_wr_ok   = i_host_wr && w_addr_ok && (r_state == S_HOLD) && !i_reinit;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    if (i_reinit) begin
      w_state_nxt = S_INIT;
      w_ptr_nxt   = '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_ptr == LAST_PTR) begin
            w_state_nxt = i_freeze ? S_HOLD : S_RUN;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt = r_ptr + NB_ADDR'(1);
          end
        end
        S_RUN:   if (i_freeze)  w_state_nxt = S_HOLD;
        S_HOLD:  if (!i_freeze) w_state_nxt = S_RUN;
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

  always_comb begin
    w_rd_tap  = '0;
    w_sat_cnt = '0;
    for (int k = 0; k < FFE_LEN; k++) begin
      w_taps_nxt[k] = r_taps[k];
      if (i_host_addr == NB_ADDR'(k)) w_rd_tap = r_taps[k];
      if (r_taps[k] == SAT_POS || r_taps[k] == SAT_NEG) w_sat_cnt = w_sat_cnt + NB_ADDR'(1);
      if (!i_reinit) begin
        if (r_state == S_INIT && r_ptr == NB_ADDR'(k))
          w_taps_nxt[k] = (k == CENTER_TAP) ? INIT_VAL : '0;
        else if (r_state == S_RUN && i_update_en)
          w_taps_nxt[k] = i_new_coeff[k*NB +: NB];
        else if (w_wr_ok && i_host_addr == NB_ADDR'(k))
          w_taps_nxt[k] = i_host_wdata;
      end
    end
  end

  // Host responses are registered; a reinit edge swallows any access in flight.
  always_comb begin
    w_rdata_nxt  = r_rdata;
    w_rvalid_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    if (!i_reinit) begin
      if (r_state == S_INIT) begin
        w_err_nxt = i_host_rd || i_host_wr;
      end else begin
        if (i_host_rd) begin
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = w_addr_ok ? w_rd_tap : '0;
          if (!w_addr_ok) w_err_nxt = 1'b1;
        end
        if (i_host_wr && !w_wr_ok) w_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_INIT;
      r_ptr    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_ready  <= 1'b0;
      r_count  <= '0;
      r_sat    <= '0;
      for (int k = 0; k < FFE_LEN; k++) r_taps[k] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rdata  <= w_rdata_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_err    <= w_err_nxt;
      r_ready  <= (w_state_nxt != S_INIT);
      r_sat    <= w_sat_cnt;
      for (int k = 0; k < FFE_LEN; k++) r_taps[k] <= w_taps_nxt[k];
      if (!i_reinit && r_state == S_RUN && i_update_en && r_count != '1)
        r_count <= r_count + 32'd1;
    end
  end

  always_comb begin
    o_coeff_flat = '0;
    for (int k = 0; k < FFE_LEN; k++) o_coeff_flat[k*NB +: NB] = r_taps[k];
  end

  assign o_host_rdata   = r_rdata;
  assign o_host_rvalid  = r_rvalid;
  assign o_host_err     = r_err;
  assign o_ready        = r_ready;
  assign o_update_count = r_count;
  assign o_sat_taps     = r_sat;

endmodule

// File: tb/tb_ffe_coeff_bank.sv
// tb/tb_ffe_coeff_bank.sv - directed self-checking bench for ffe_coeff_bank.
module tb_ffe_coeff_bank;

  logic         clk = 1'b0;
  logic         reset, update_en, freeze, reinit, host_wr, host_rd;
  logic [167:0] new_coeff;
  logic [4:0]   host_addr;
  logic [7:0]   host_wdata;
  logic [7:0]   host_rdata;
  logic         host_rvalid, host_err, ready;
  logic [167:0] coeff_flat;
  logic [31:0]  update_count;
  logic [4:0]   sat_taps;

  int n_checks = 0;
  int n_errors = 0;
  logic [167:0] exp_spike;

  always #5 clk = ~clk;

  ffe_coeff_bank dut (
    .i_clock(clk), .i_reset(reset), .i_update_en(update_en), .i_new_coeff(new_coeff),
    .i_freeze(freeze), .i_reinit(reinit), .i_host_wr(host_wr), .i_host_rd(host_rd),
    .i_host_addr(host_addr), .i_host_wdata(host_wdata), .o_host_rdata(host_rdata),
    .o_host_rvalid(host_rvalid), .o_host_err(host_err), .o_coeff_flat(coeff_flat),
    .o_ready(ready), .o_update_count(update_count), .o_sat_taps(sat_taps)
  );

  task automatic check_eq(input string tag, input logic [167:0] got, input logic [167:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tap(input int k);
    return coeff_flat[k*8 +: 8];
  endfunction

  initial begin
    exp_spike = '0;
    exp_spike[80 +: 8] = 8'h7F;
    reset = 1'b1; update_en = 1'b0; freeze = 1'b0; reinit = 1'b0;
    host_wr = 1'b0; host_rd = 1'b0; new_coeff = '0; host_addr = '0; host_wdata = '0;
    tick(); tick();
    check_eq("rst_ready", ready, 0);
    check_eq("rst_count", update_count, 0);
    check_eq("rst_rvalid", host_rvalid, 0);
    check_eq("rst_err", host_err, 0);
    check_eq("rst_rdata", host_rdata, 0);
    check_eq("rst_sat", sat_taps, 0);
    check_eq("rst_coeff", coeff_flat, 0);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      check_eq("init_ready_low", ready, 0);
      tick();
    end
    check_eq("init_ready_high", ready, 1);
    check_eq("init_spike", coeff_flat, exp_spike);
    check_eq("init_sat", sat_taps, 1);

    new_coeff = {21{8'h05}};
    update_en = 1'b1;
    tick();
    check_eq("upd_latency", coeff_flat, {21{8'h05}});
    tick(); tick();
    update_en = 1'b0;
    check_eq("upd_count3", update_count, 3);
    check_eq("upd_sat0", sat_taps, 0);

    freeze = 1'b1;
    tick();
    new_coeff = {21{8'h11}};
    update_en = 1'b1;
    tick();
    update_en = 1'b0;
    check_eq("hold_taps", coeff_flat, {21{8'h05}});
    check_eq("hold_count", update_count, 3);

    host_wr = 1'b1; host_addr = 5'd3; host_wdata = 8'h80;
    tick();
    host_wr = 1'b0;
    check_eq("hwr_tap3", tap(3), 8'h80);
    check_eq("hwr_no_err", host_err, 0);
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    check_eq("hrd_rdata", host_rdata, 8'h80);
    check_eq("hrd_rvalid", host_rvalid, 1);
    check_eq("hrd_err", host_err, 0);
    check_eq("hold_sat_neg", sat_taps, 1);
    tick();
    check_eq("hrd_rvalid_pulse", host_rvalid, 0);

    host_rd = 1'b1; host_wr = 1'b1; host_wdata = 8'h22;
    tick();
    host_rd = 1'b0; host_wr = 1'b0;
    check_eq("rw_prewrite", host_rdata, 8'h80);
    check_eq("rw_tap3", tap(3), 8'h22);

    host_wr = 1'b1; host_addr = 5'd21; host_wdata = 8'h7F;
    tick();
    host_wr = 1'b0;
    check_eq("hwr_oob_err", host_err, 1);
    tick();
    check_eq("hwr_err_pulse", host_err, 0);

    freeze = 1'b0;
    tick();
    host_wr = 1'b1; host_addr = 5'd2; host_wdata = 8'h33;
    tick();
    host_wr = 1'b0;
    check_eq("run_wr_tap2", tap(2), 8'h05);
    check_eq("run_wr_err", host_err, 1);
    host_rd = 1'b1; host_addr = 5'd25;
    tick();
    host_rd = 1'b0;
    check_eq("oob_rdata", host_rdata, 0);
    check_eq("oob_rvalid", host_rvalid, 1);
    check_eq("oob_err", host_err, 1);

    reinit = 1'b1; update_en = 1'b1; new_coeff = {21{8'h44}};
    tick();
    reinit = 1'b0; update_en = 1'b0;
    check_eq("reinit_ready", ready, 0);
    check_eq("reinit_drop_upd", tap(0), 8'h05);
    check_eq("reinit_count", update_count, 3);
    host_rd = 1'b1; host_addr = 5'd0;
    tick();
    host_rd = 1'b0;
    check_eq("init_rd_err", host_err, 1);
    check_eq("init_rd_rvalid", host_rvalid, 0);
    check_eq("reinit_ready_w1", ready, 0);
    for (int i = 0; i < 19; i++) begin
      tick();
      check_eq("reinit_ready_low", ready, 0);
    end
    tick();
    check_eq("reinit_ready_high", ready, 1);
    check_eq("reinit_spike", coeff_flat, exp_spike);
    check_eq("reinit_count_kept", update_count, 3);

    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_ready", ready, 0);
    check_eq("mid_rst_count", update_count, 0);
    check_eq("mid_rst_coeff", coeff_flat, 0);
    check_eq("mid_rst_sat", sat_taps, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("mid_rst_ready_low", ready, 0);
    end
    tick();
    check_eq("mid_rst_ready_high", ready, 1);
    check_eq("mid_rst_spike", coeff_flat, exp_spike);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
